// File: rtl/bin_pkg.sv
// Shared types and image constants for the binarization run controller.
package bin_pkg;

  localparam int IMG_WIDTH  = 256;
  localparam int IMG_HEIGHT = 256;
  localparam int IMG_ADDR_W = 16;
  localparam int THRES_MAX  = 127;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INT_PULSE,
    ST_INT_ACK,
    ST_INT_RUN,
    ST_BIN_PULSE,
    ST_BIN_ACK,
    ST_BIN_RUN,
    ST_READ,
    ST_DONE
  } bin_state_e;

  function automatic logic [7:0] sat_thres(input logic [7:0] t, input logic [7:0] lim);
    return (t > lim) ? lim : t;
  endfunction

endpackage

// File: rtl/bin_sequencer_if.sv
// Valid/ready stream carrying the binary map out of the sequencer.
interface bin_sequencer_if #(
  parameter int ADDR_W = bin_pkg::IMG_ADDR_W
);
  logic              out_valid;
  logic              out_ready;
  logic              out_pixel;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (output out_valid, output out_pixel, output out_addr, output out_last,
                  input out_ready);
  modport slave  (input out_valid, input out_pixel, input out_addr, input out_last,
                  output out_ready);
endinterface

// File: rtl/bin_out_stage.sv
// Single-entry output register: loads when empty or when its beat is taken,
// and refuses further loads once the final beat is held.
module bin_out_stage #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              en_i,
  input  logic              pixel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              load_o,
  output logic              valid_o,
  output logic              pixel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic              valid_q;
  logic              pixel_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;

  assign load_o = en_i && (!valid_q || (ready_i && !last_q));

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
      pixel_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_o) begin
      valid_q <= 1'b1;
      pixel_q <= pixel_i;
      addr_q  <= addr_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pixel_o = pixel_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;
endmodule

// File: rtl/bin_sequencer.sv
// Run controller: integral pass, binarization pass, then raster readout.
// Optional watchdog on the wait states is enabled with BIN_SEQ_TIMEOUT_EN.
module bin_sequencer import bin_pkg::*; #(
  parameter int WIDTH     = IMG_WIDTH,
  parameter int HEIGHT    = IMG_HEIGHT,
  parameter int ADDR_W    = IMG_ADDR_W,
  parameter int THRES_MAX = bin_pkg::THRES_MAX
`ifdef BIN_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 70000
`endif
) (
  input  logic                bin_clk,
  input  logic                bin_rst,
  input  logic                start,
  input  logic [7:0]          thres_in,
  input  logic [1:0]          core_status,
  output logic                int_ctrl,
  output logic                bin_ctrl,
  output logic [7:0]          thres_length,
  output logic [ADDR_W-1:0]   pixel_address,
  input  logic                bin_data,
  bin_sequencer_if.master     out_if,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam logic [7:0]        THRES_SAT = 8'(THRES_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  bin_state_e        state_q, state_d;
  logic [7:0]        thres_q;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              at_last;
  logic              read_en;
  logic              load;
  logic              timeout;

  // The core is not reset with us, so a start is only taken once it is idle.
  assign accept  = (state_q == ST_IDLE) && start && (core_status == 2'b00);
  assign at_last = (addr_q == LAST_ADDR);
  assign read_en = (state_q == ST_READ);

  always_ff @(posedge bin_clk) begin
    if (bin_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept) state_d = ST_INT_PULSE;
      ST_INT_PULSE: state_d = ST_INT_ACK;
      ST_INT_ACK:   if (timeout) state_d = ST_IDLE;
                    else if (core_status[0]) state_d = ST_INT_RUN;
      ST_INT_RUN:   if (timeout) state_d = ST_IDLE;
                    else if (!core_status[0]) state_d = ST_BIN_PULSE;
      ST_BIN_PULSE: state_d = ST_BIN_ACK;
      ST_BIN_ACK:   if (timeout) state_d = ST_IDLE;
                    else if (core_status[1]) state_d = ST_BIN_RUN;
      ST_BIN_RUN:   if (timeout) state_d = ST_IDLE;
                    else if (!core_status[1]) state_d = ST_READ;
      ST_READ:      if (out_if.out_valid && out_if.out_ready && out_if.out_last) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    int_ctrl = 1'b0;
    bin_ctrl = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      ST_IDLE:      busy     = 1'b0;
      ST_INT_PULSE: int_ctrl = 1'b1;
      ST_BIN_PULSE: bin_ctrl = 1'b1;
      ST_DONE:      done     = 1'b1;
      default:      ;
    endcase
  end

  // Address wraps to zero after the final load and stays there until the next run.
  always_ff @(posedge bin_clk) begin
    if (bin_rst) begin
      thres_q <= 8'd0;
      addr_q  <= '0;
    end else begin
      if (accept) begin
        thres_q <= sat_thres(thres_in, THRES_SAT);
        addr_q  <= '0;
      end else if (load) begin
        addr_q  <= at_last ? '0 : addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef BIN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          wait_state;
  logic          error_q;

  assign wait_state = (state_q == ST_INT_ACK) || (state_q == ST_INT_RUN) ||
                      (state_q == ST_BIN_ACK) || (state_q == ST_BIN_RUN);
  assign timeout    = wait_state && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (!wait_state || (state_d != state_q)) timer_d = '0;
  end

  always_ff @(posedge bin_clk) begin
    if (bin_rst) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      if (accept)       error_q <= 1'b0;
      else if (timeout) error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  bin_out_stage #(.ADDR_W(ADDR_W)) u_out_stage (
    .clk     (bin_clk),
    .srst    (bin_rst),
    .en_i    (read_en),
    .pixel_i (bin_data),
    .addr_i  (addr_q),
    .last_i  (at_last),
    .ready_i (out_if.out_ready),
    .load_o  (load),
    .valid_o (out_if.out_valid),
    .pixel_o (out_if.out_pixel),
    .addr_o  (out_if.out_addr),
    .last_o  (out_if.out_last)
  );

  assign thres_length  = thres_q;
  assign pixel_address = addr_q;
endmodule

// File: tb/tb_bin_sequencer.sv
// Directed bench for bin_sequencer with a small core model and a stream scoreboard.
module tb_bin_sequencer;
  localparam int AW       = 8;
  localparam int NPIX     = 256;
  localparam int BUSY_LEN = 20;

  logic          bin_clk = 1'b0;
  logic          bin_rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    thres_in = 8'd0;
  logic [1:0]    core_status = 2'b00;
  logic          int_ctrl, bin_ctrl, bin_data, busy, done, error;
  logic [7:0]    thres_length;
  logic [AW-1:0] pixel_address;

  bin_sequencer_if #(.ADDR_W(AW)) out_if ();

  bin_sequencer #(
    .WIDTH(16), .HEIGHT(16), .ADDR_W(AW)
`ifdef BIN_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .bin_clk(bin_clk), .bin_rst(bin_rst), .start(start), .thres_in(thres_in),
    .core_status(core_status), .int_ctrl(int_ctrl), .bin_ctrl(bin_ctrl),
    .thres_length(thres_length), .pixel_address(pixel_address), .bin_data(bin_data),
    .out_if(out_if), .busy(busy), .done(done), .error(error)
  );

  always #5 bin_clk = ~bin_clk;

  function automatic logic map_bit(input logic [AW-1:0] a);
    return a[0] ^ a[2];
  endfunction

  assign bin_data = map_bit(pixel_address);

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Core model: busy flag rises two cycles after its start pulse and lasts BUSY_LEN cycles.
  int         int_age = 1000;
  int         bin_age = 1000;
  logic       never_ack = 1'b0;
  logic       core_force = 1'b0;
  logic [1:0] core_force_val = 2'b00;

  always @(negedge bin_clk) begin
    if (int_ctrl && !never_ack) int_age = 0;
    else if (int_age < 1000) int_age++;
    if (bin_ctrl) bin_age = 0;
    else if (bin_age < 1000) bin_age++;
    if (core_force) core_status = core_force_val;
    else core_status = {(bin_age >= 2 && bin_age < 2 + BUSY_LEN),
                        (int_age >= 2 && int_age < 2 + BUSY_LEN)};
  end

  logic       bp_mode = 1'b0;
  logic [3:0] rpat = 4'b1001;
  int         rcyc = 0;

  initial begin
    out_if.out_ready = 1'b1;
    forever begin
      @(posedge bin_clk);
      #1;
      rcyc++;
      out_if.out_ready = bp_mode ? rpat[rcyc % 4] : 1'b1;
    end
  end

  // Scoreboard: the stream must be addresses 0..NPIX-1 in order, each exactly once.
  int         exp_idx = 0;
  int         int_cnt = 0, bin_cnt = 0, done_cnt = 0, beat_cnt = 0, last_cnt = 0, vcyc_cnt = 0;
  logic [7:0] exp_thres = 8'd0;
  logic [7:0] first_bits = 8'd0;

  always @(negedge bin_clk) begin
    if (bin_rst) begin
      exp_idx = 0;
    end else begin
      check("ctrl_exclusive", 32'(int_ctrl & bin_ctrl), 32'd0);
      if (int_ctrl) int_cnt++;
      if (bin_ctrl) bin_cnt++;
      if (busy) check("thres_hold", 32'(thres_length), 32'(exp_thres));
      if (out_if.out_valid) begin
        vcyc_cnt++;
        check("beat_addr", 32'(out_if.out_addr), 32'(exp_idx));
        check("beat_pixel", 32'(out_if.out_pixel), 32'(map_bit(AW'(exp_idx))));
        check("beat_last", 32'(out_if.out_last), 32'(exp_idx == NPIX - 1));
        if (exp_idx < 8) first_bits[exp_idx[2:0]] = out_if.out_pixel;
        if (out_if.out_ready) begin
          beat_cnt++;
          if (out_if.out_last) last_cnt++;
          exp_idx++;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_all_beats", 32'(exp_idx), 32'(NPIX));
        exp_idx = 0;
      end
    end
  end

  task automatic do_run(input logic [7:0] thr, input logic [7:0] want, input bit gate,
                        input string tag, output int vcycles);
    int i0, b0, d0, be0, l0, v0, n;
    i0 = int_cnt; b0 = bin_cnt; d0 = done_cnt; be0 = beat_cnt; l0 = last_cnt; v0 = vcyc_cnt;
    @(posedge bin_clk); #1;
    thres_in = thr; start = 1'b1; exp_thres = want;
    @(posedge bin_clk); #1;
    start = 1'b0; thres_in = 8'hFF;
    @(negedge bin_clk);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_int_pulse", 32'(int_ctrl), 32'd1);
    check("accept_thres", 32'(thres_length), 32'(want));
    check("accept_error_clear", 32'(error), 32'd0);
    if (gate) begin
      n = 0;
      while (!core_status[1] && n < 500) begin @(negedge bin_clk); n++; end
      check("gate_reach_bin_run", 32'(n < 500), 32'd1);
      @(posedge bin_clk); #1; start = 1'b1; thres_in = 8'd50;
      @(posedge bin_clk); #1; start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin @(negedge bin_clk); n++; end
    check("run_done_count", 32'(done_cnt - d0), 32'd1);
    @(negedge bin_clk);
    check("idle_after_done", 32'(busy), 32'd0);
    check("int_pulses", 32'(int_cnt - i0), 32'd1);
    check("bin_pulses", 32'(bin_cnt - b0), 32'd1);
    check("beats", 32'(beat_cnt - be0), 32'(NPIX));
    check("last_flags", 32'(last_cnt - l0), 32'd1);
    vcycles = vcyc_cnt - v0;
    $display("run %s: thres_in=%0d thres_length=%0d beats=%0d valid_cycles=%0d",
             tag, thr, want, beat_cnt - be0, vcycles);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vc, n, i0, d0;
    repeat (3) @(posedge bin_clk);
    @(negedge bin_clk);
    check("rst_flags", {24'd0, int_ctrl, bin_ctrl, out_if.out_valid, out_if.out_pixel,
                        out_if.out_last, busy, done, error}, 32'd0);
    check("rst_thres", 32'(thres_length), 32'd0);
    check("rst_pixel_address", 32'(pixel_address), 32'd0);
    check("rst_out_addr", 32'(out_if.out_addr), 32'd0);
    @(posedge bin_clk); #1;
    bin_rst = 1'b0;
    $display("reset released");

    do_run(8'd9, 8'd9, 1'b0, "nominal", vc);
    check("full_throughput_valid_cycles", 32'(vc), 32'(NPIX));
    check("map_first_bits", 32'(first_bits), 32'h5A);

    do_run(8'd200, 8'd127, 1'b0, "saturation", vc);

    bp_mode = 1'b1;
    do_run(8'd40, 8'd40, 1'b0, "backpressure", vc);
    check("backpressure_stalls_seen", 32'(vc > NPIX), 32'd1);
    bp_mode = 1'b0;

    do_run(8'd15, 8'd15, 1'b1, "start_during_bin_run", vc);

    i0 = int_cnt;
    core_force = 1'b1; core_force_val = 2'b01;
    @(negedge bin_clk);
    @(posedge bin_clk); #1; thres_in = 8'd77; start = 1'b1;
    @(posedge bin_clk); #1; start = 1'b0;
    repeat (3) begin
      @(negedge bin_clk);
      check("gated_start_busy", 32'(busy), 32'd0);
    end
    check("gated_start_no_pulse", 32'(int_cnt - i0), 32'd0);
    core_force = 1'b0;
    $display("start with core_status=01 refused");
    @(negedge bin_clk);

    @(posedge bin_clk); #1; thres_in = 8'd20; start = 1'b1; exp_thres = 8'd20;
    @(posedge bin_clk); #1; start = 1'b0;
    n = 0;
    while (!(out_if.out_valid && out_if.out_addr == AW'(100)) && n < 3000) begin
      @(negedge bin_clk); n++;
    end
    check("reach_addr_100", 32'(n < 3000), 32'd1);
    @(posedge bin_clk); #1; bin_rst = 1'b1;
    @(posedge bin_clk); #1; bin_rst = 1'b0;
    @(negedge bin_clk);
    check("midrun_rst_valid", 32'(out_if.out_valid), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_pixel_address", 32'(pixel_address), 32'd0);
    $display("reset during readout applied");
    do_run(8'd33, 8'd33, 1'b0, "after_reset", vc);

`ifdef BIN_SEQ_TIMEOUT_EN
    never_ack = 1'b1;
    d0 = done_cnt;
    @(posedge bin_clk); #1; thres_in = 8'd10; start = 1'b1; exp_thres = 8'd10;
    @(posedge bin_clk); #1; start = 1'b0;
    n = 0;
    while (!error && n < 300) begin @(negedge bin_clk); n++; end
    check("timeout_cycle", 32'(n), 32'd102);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    never_ack = 1'b0;
    $display("watchdog fired after %0d cycles", n);
    do_run(8'd12, 8'd12, 1'b0, "after_timeout", vc);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
